// File: rtl/ioshim_memio_host.sv
// Byte-stream command host driving the CPU memory port (SETADDR / WRITE / READ / BURST).
// Define IOSHIM_MEMIO_HOST_BURST_EN to enable multi-word BURST reads; otherwise BURST answers 8'hEE.
module ioshim_memio_host #(
   parameter int BURST_MAX = 64
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        memio_rd,
   output logic [1:0]  memio_wr,
   output logic [10:0] memio_addr,
   output logic [15:0] memio_wdata,
   input  logic [15:0] memio_rdata,
   input  logic        memio_done
);

   typedef enum logic [2:0] {IDLE, ARG_HI, ARG_LO, REQ, RESP_HI, RESP_LO} state_t;

   localparam logic [1:0] OP_SETADDR = 2'b00;
   localparam logic [1:0] OP_WRITE   = 2'b01;
   localparam logic [1:0] OP_READ    = 2'b10;

   state_t      state, state_nxt;
   logic [1:0]  op, op_nxt;
   logic [7:0]  arg_hi, arg_hi_nxt;
   logic [7:0]  rd_lo, rd_lo_nxt;
   logic [10:0] addr, addr_nxt;
   logic        memio_rd_nxt;
   logic [1:0]  memio_wr_nxt;
   logic [10:0] memio_addr_nxt;
   logic [15:0] memio_wdata_nxt;
   logic [7:0]  out_data_nxt;
   logic        xfer_in;
`ifdef IOSHIM_MEMIO_HOST_BURST_EN
   localparam logic [6:0] BMAX = 7'(BURST_MAX);
   logic [5:0] burst_rem, burst_rem_nxt;
   logic [6:0] len_req;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         op          <= OP_SETADDR;
         arg_hi      <= '0;
         rd_lo       <= '0;
         addr        <= '0;
         memio_rd    <= 1'b0;
         memio_wr    <= 2'b00;
         memio_addr  <= '0;
         memio_wdata <= '0;
         out_data    <= '0;
`ifdef IOSHIM_MEMIO_HOST_BURST_EN
         burst_rem   <= '0;
`endif
      end else begin
         state       <= state_nxt;
         op          <= op_nxt;
         arg_hi      <= arg_hi_nxt;
         rd_lo       <= rd_lo_nxt;
         addr        <= addr_nxt;
         memio_rd    <= memio_rd_nxt;
         memio_wr    <= memio_wr_nxt;
         memio_addr  <= memio_addr_nxt;
         memio_wdata <= memio_wdata_nxt;
         out_data    <= out_data_nxt;
`ifdef IOSHIM_MEMIO_HOST_BURST_EN
         burst_rem   <= burst_rem_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt       = state;
      op_nxt          = op;
      arg_hi_nxt      = arg_hi;
      rd_lo_nxt       = rd_lo;
      addr_nxt        = addr;
      memio_rd_nxt    = memio_rd;
      memio_wr_nxt    = memio_wr;
      memio_addr_nxt  = memio_addr;
      memio_wdata_nxt = memio_wdata;
      out_data_nxt    = out_data;
`ifdef IOSHIM_MEMIO_HOST_BURST_EN
      burst_rem_nxt   = burst_rem;
      len_req         = {1'b0, in_data[5:0]} + 7'd1;
      if (len_req > BMAX) len_req = BMAX;
`endif
      in_ready  = resetn && (state == IDLE || state == ARG_HI || state == ARG_LO);
      out_valid = (state == RESP_HI || state == RESP_LO);
      xfer_in   = in_valid && in_ready;

      case (state)
         IDLE: if (xfer_in) begin
            op_nxt = in_data[7:6];
            case (in_data[7:6])
               OP_SETADDR, OP_WRITE: state_nxt = ARG_HI;
               OP_READ: begin
                  memio_rd_nxt   = 1'b1;
                  memio_addr_nxt = addr;
                  state_nxt      = REQ;
`ifdef IOSHIM_MEMIO_HOST_BURST_EN
                  burst_rem_nxt  = '0;
`endif
               end
               default: begin
`ifdef IOSHIM_MEMIO_HOST_BURST_EN
                  memio_rd_nxt   = 1'b1;
                  memio_addr_nxt = addr;
                  burst_rem_nxt  = 6'(len_req - 7'd1);
                  state_nxt      = REQ;
`else
                  // Burst disabled: answer with a single 8'hEE byte; RESP_LO then returns straight to IDLE.
                  out_data_nxt   = 8'hEE;
                  state_nxt      = RESP_LO;
`endif
               end
            endcase
         end
         ARG_HI: if (xfer_in) begin
            arg_hi_nxt = in_data;
            state_nxt  = ARG_LO;
         end
         ARG_LO: if (xfer_in) begin
            if (op == OP_SETADDR) begin
               addr_nxt  = {arg_hi[2:0], in_data};
               state_nxt = IDLE;
            end else begin
               memio_wr_nxt    = 2'b11;
               memio_wdata_nxt = {arg_hi, in_data};
               memio_addr_nxt  = addr;
               state_nxt       = REQ;
            end
         end
         REQ: if (memio_done) begin
            memio_rd_nxt = 1'b0;
            memio_wr_nxt = 2'b00;
            addr_nxt     = addr + 11'd1;
            if (memio_wr != 2'b00) begin
               state_nxt = IDLE;
            end else begin
               out_data_nxt = memio_rdata[15:8];
               rd_lo_nxt    = memio_rdata[7:0];
               state_nxt    = RESP_HI;
            end
         end
         RESP_HI: if (out_ready) begin
            out_data_nxt = rd_lo;
            state_nxt    = RESP_LO;
         end
         RESP_LO: if (out_ready) begin
            state_nxt = IDLE;
`ifdef IOSHIM_MEMIO_HOST_BURST_EN
            if (burst_rem != '0) begin
               burst_rem_nxt  = burst_rem - 6'd1;
               memio_rd_nxt   = 1'b1;
               memio_addr_nxt = addr;
               state_nxt      = REQ;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
